// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders + OR) swept LSB-first over WIDTH bits.
// Optional subtract mode enabled by defining SERIAL_SUB_EN (adds input port sub).
module serial_adder_ha (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q, s_q;
  logic               carry_q, c_q, busy_q, done_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               p, g1, g2, bit_s;
  logic               carry_d;
  logic [WIDTH-1:0]   sum_d;
  logic [WIDTH-1:0]   b_load;
  logic               carry_init;

  serial_adder_ha u_ha0 (.x_i(a_q[0]), .y_i(b_q[0]),  .s_o(p),     .c_o(g1));
  serial_adder_ha u_ha1 (.x_i(p),      .y_i(carry_q), .s_o(bit_s), .c_o(g2));

  always_comb begin
    carry_d = g1 | g2;
    sum_d   = {bit_s, sum_q[WIDTH-1:1]};
  end

`ifdef SERIAL_SUB_EN
  // Subtraction is A + ~B + 1: invert B on load and seed the carry.
  always_comb begin
    b_load     = sub ? ~inB : inB;
    carry_init = sub;
  end
`else
  always_comb begin
    b_load     = inB;
    carry_init = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= inA;
            b_q     <= b_load;
            carry_q <= carry_init;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            s_q     <= sum_d;
            c_q     <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign c    = c_q;
endmodule
